reg_writeback_arbiter: RTL and testbench
========================================

Name: reg_writeback_arbiter

Overview:
- Write-side producer for the 64-bit, 32-entry integer register file. It owns the single write port: RegWrite, WriteReg and WriteData.
- Merges two result sources: single-cycle ALU results, which cannot stall, and long-latency load/store results, which use a valid/ready handshake and are buffered in a small FIFO.
- Keeps a pending-destination scoreboard so decode can detect RAW hazards on registers whose long-latency result has not yet been written back.

Parameters:
- XLEN, 64, data width of a register.
- FIFO_DEPTH, 4, number of load/store result entries buffered. Must be a power of two, at least 2.
- NREG, 32, number of architectural registers. Register index width is 5.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load/store result offered.
- lsu_ready  out  1  FIFO can accept a load/store result.
- lsu_rd  in  5  load/store destination register.
- lsu_data  in  XLEN  load data.
- issue_valid  in  1  a long-latency op is issued this cycle.
- issue_rd  in  5  destination register of the issued op.
- busy  out  NREG  scoreboard, one pending bit per register.
- fifo_count  out  3  FIFO occupancy, 0..FIFO_DEPTH.
- RegWrite  out  1  register-file write enable (registered).
- WriteReg  out  5  register-file write index (registered).
- WriteData  out  XLEN  register-file write data (registered).

Behaviour:
- Reset (any cycle, including mid-drain):
  - RegWrite=0, WriteReg=0, WriteData=0.
  - FIFO emptied; fifo_count=0; lsu_ready=1.
  - busy=0.
- Load/store accept:
  - lsu_ready = (fifo_count != FIFO_DEPTH). This is registered-count based, so there is no same-cycle pass-through when full.
  - A transfer occurs when lsu_valid & lsu_ready. {lsu_rd, lsu_data} is pushed at the tail.
  - The FIFO head is never written in the accept cycle, so minimum load-to-write latency is 2 cycles.
- Arbitration, evaluated each cycle:
  - ALU has absolute priority. If alu_valid, the next edge loads RegWrite=(alu_rd!=0), WriteReg=alu_rd, WriteData=alu_data.
  - Otherwise, if the FIFO is non-empty, the head is popped and the next edge loads RegWrite=(head_rd!=0), WriteReg=head_rd, WriteData=head_data.
  - Otherwise RegWrite=0. WriteReg and WriteData hold their previous values.
- Write latency is exactly 1 cycle from the selected source to the write port.
- x0 writes: RegWrite stays 0, but the source is still consumed (ALU result dropped, FIFO entry popped).
- Simultaneous push and pop: count unchanged, pointers both advance, wrapping modulo FIFO_DEPTH.
- A push while full cannot occur because lsu_ready=0.
- Starvation: continuous alu_valid stalls the drain indefinitely. Upstream must insert an ALU bubble when fifo_count==FIFO_DEPTH; this is not checked here.
- Scoreboard:
  - Set: issue_valid & issue_rd!=0 sets busy[issue_rd] at the next edge.
  - Clear: a FIFO pop with head_rd!=0 clears busy[head_rd] at the same edge it drives RegWrite.
  - Set and clear of the same index in the same cycle: set wins.
  - An ALU write to a busy register does not change busy.
  - busy[0] is always 0.

Decomposition:
- Shared package holds:
  - XLEN, NREG, REG_IDX_W=5.
  - A wb_entry_t struct {rd[4:0], data[XLEN-1:0]}.
- One natural sub-module: wb_fifo, a parameterised sync FIFO with push/pop/full/empty/count. Arbitration and the scoreboard stay in the top module.

Test Plan:
- Reset, then a single ALU result:
  - Stimulus: alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle.
  - Response: next cycle RegWrite=1, WriteReg=5, WriteData=0x1234; the following cycle RegWrite=0.
- Issue and load writeback clears busy:
  - Stimulus: issue rd=7; 3 cycles later lsu_valid with rd=7, data=0xDEAD, ALU idle.
  - Response: busy[7]=1 from issue+1. RegWrite with WriteReg=7, WriteData=0xDEAD at accept+2. busy[7]=0 in that same cycle.
- Contention:
  - Stimulus: push load rd=3 while the ALU writes rd=4, rd=6, rd=8 on consecutive cycles.
  - Response: writes appear in order 4, 6, 8, then 3. fifo_count holds 1 until the drain.
- FIFO full and wrap:
  - Stimulus: push 4 loads (rd=1..4) with the ALU continuously valid.
  - Response: lsu_ready=0 and fifo_count=4. After the ALU goes idle, writes appear in order rd=1..4. Then push 2 more and confirm the wrap order is preserved.
- x0 and set-wins:
  - Stimulus: load rd=0 data=0xFF; separately, issue rd=9 in the same cycle a FIFO entry with rd=9 is popped.
  - Response: the rd=0 load gives RegWrite=0 with fifo_count decremented. busy[9] remains 1.
- Reset mid-operation:
  - Stimulus: 3 FIFO entries and busy={2,3}; assert reset for 1 cycle.
  - Response: fifo_count=0, busy=0, RegWrite=0, lsu_ready=1. No stale write appears afterwards.

Source files
------------

// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback path.
// Register indices are 5 bits wide; wb_entry_t is one buffered load/store result.
package reg_writeback_arbiter_pkg;

   localparam int unsigned XLEN      = 64;
   localparam int unsigned NREG      = 32;
   localparam int unsigned REG_IDX_W = 5;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_entry_t;

endpackage

// File: rtl/reg_writeback_arbiter_wb_fifo.sv
// Synchronous FIFO for buffered load/store results. The head is registered storage,
// so an entry pushed this cycle can be popped at the earliest on the next cycle.
module wb_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CntW-1:0]  count
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;

   // Storage carries no reset; validity is tracked by count and pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == CntW'(Depth));
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Single write-port producer for the integer register file: ALU results win outright,
// buffered load/store results drain when the ALU is idle, and a busy scoreboard tracks them.
module reg_writeback_arbiter
   import reg_writeback_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alu_valid,
   input  logic [REG_IDX_W-1:0] alu_rd,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 lsu_valid,
   output logic                 lsu_ready,
   input  logic [REG_IDX_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]      lsu_data,
   input  logic                 issue_valid,
   input  logic [REG_IDX_W-1:0] issue_rd,
   output logic [NREG-1:0]      busy,
   output logic [CntW-1:0]      fifo_count,
   output logic                 RegWrite,
   output logic [REG_IDX_W-1:0] WriteReg,
   output logic [XLEN-1:0]      WriteData
);

   logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
   wb_entry_t push_entry, head;

   logic                 reg_write_q, reg_write_d;
   logic [REG_IDX_W-1:0] write_reg_q, write_reg_d;
   logic [XLEN-1:0]      write_data_q, write_data_d;
   logic [NREG-1:0]      busy_q, busy_d;

   assign lsu_ready  = !fifo_full;
   assign fifo_push  = lsu_valid && lsu_ready;
   assign fifo_pop   = !alu_valid && !fifo_empty;
   assign push_entry = '{rd: lsu_rd, data: lsu_data};

   wb_fifo #(
      .Width ($bits(wb_entry_t)),
      .Depth (FIFO_DEPTH)
   ) u_wb_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (alu_valid) begin
         reg_write_d  = (alu_rd != '0);
         write_reg_d  = alu_rd;
         write_data_d = alu_data;
      end else if (fifo_pop) begin
         reg_write_d  = (head.rd != '0);
         write_reg_d  = head.rd;
         write_data_d = head.data;
      end
   end

   // Clear before set so a same-cycle issue to the popped register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (fifo_pop && head.rd != '0) begin
         busy_d[head.rd] = 1'b0;
      end
      if (issue_valid && issue_rd != '0) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         busy_q       <= '0;
      end else begin
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
      end
   end

   assign RegWrite  = reg_write_q;
   assign WriteReg  = write_reg_q;
   assign WriteData = write_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: directed scenarios plus random traffic, all
// checked each cycle against a queue-based reference model.
module tb_reg_writeback_arbiter;
   import reg_writeback_arbiter_pkg::*;

   localparam int unsigned Depth = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, lsu_valid, issue_valid;
   logic [4:0]  alu_rd, lsu_rd, issue_rd;
   logic [63:0] alu_data, lsu_data;
   logic        lsu_ready;
   logic [31:0] busy;
   logic [2:0]  fifo_count;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [63:0] WriteData;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state
   wb_entry_t   m_q[$];
   logic [31:0] m_busy;
   logic        m_we;
   logic [4:0]  m_wr;
   logic [63:0] m_wd;

   always #5 clk = ~clk;

   reg_writeback_arbiter #(
      .FIFO_DEPTH (Depth)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .RegWrite    (RegWrite),
      .WriteReg    (WriteReg),
      .WriteData   (WriteData)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, compare the DUT with the model, then advance both.
   task automatic step(input logic rst,
                       input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                       input logic iv, input logic [4:0] ird);
      bit        ready;
      wb_entry_t h;
      reset = rst;
      alu_valid = av;   alu_rd = ard;   alu_data = ad;
      lsu_valid = lv;   lsu_rd = lrd;   lsu_data = ld;
      issue_valid = iv; issue_rd = ird;
      #1;
      check_eq("RegWrite",   RegWrite,   m_we);
      check_eq("WriteReg",   WriteReg,   m_wr);
      check_eq("WriteData",  WriteData,  m_wd);
      check_eq("fifo_count", fifo_count, m_q.size());
      ready = (m_q.size() != Depth);
      check_eq("lsu_ready",  lsu_ready,  ready);
      check_eq("busy",       busy,       m_busy);
      if (rst) begin
         m_q.delete();
         m_busy = '0; m_we = 1'b0; m_wr = '0; m_wd = '0;
      end else begin
         if (av) begin
            m_we = (ard != 0); m_wr = ard; m_wd = ad;
         end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_we = (h.rd != 0); m_wr = h.rd; m_wd = h.data;
            if (h.rd != 0) m_busy[h.rd] = 1'b0;
         end else begin
            m_we = 1'b0;
         end
         if (lv && ready) m_q.push_back('{rd: lrd, data: ld});
         if (iv && ird != 0) m_busy[ird] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      m_busy = '0; m_we = 1'b0; m_wr = '0; m_wd = '0;
      reset = 1'b1;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      issue_valid = 0; issue_rd = 0;
      @(posedge clk);
      #1;
      // Model starts in the reset state; the first step's comparisons cover reset values.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("rst_regwrite", RegWrite, 0);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_ready", lsu_ready, 1);
      check_eq("rst_busy", busy, 0);

      // Single ALU result
      step(0, 1, 5, 64'h1234, 0, 0, 0, 0, 0);
      check_eq("alu_we", RegWrite, 1);
      check_eq("alu_reg", WriteReg, 5);
      check_eq("alu_data", WriteData, 64'h1234);
      idle();
      check_eq("alu_we_off", RegWrite, 0);

      // Issue then load writeback clears busy
      step(0, 0, 0, 0, 0, 0, 0, 1, 7);
      check_eq("busy7_set", busy[7], 1);
      idle(); idle();
      step(0, 0, 0, 0, 1, 7, 64'hDEAD, 0, 0);
      check_eq("ld_accept_no_we", RegWrite, 0);
      idle();
      check_eq("ld_we", RegWrite, 1);
      check_eq("ld_reg", WriteReg, 7);
      check_eq("ld_data", WriteData, 64'hDEAD);
      check_eq("busy7_clr", busy[7], 0);

      // Contention: ALU writes 4,6,8 ahead of load 3
      step(0, 1, 4, 64'h44, 1, 3, 64'h33, 0, 0);
      check_eq("cont_w4", WriteReg, 4);
      step(0, 1, 6, 64'h66, 0, 0, 0, 0, 0);
      check_eq("cont_w6", WriteReg, 6);
      check_eq("cont_cnt", fifo_count, 1);
      step(0, 1, 8, 64'h88, 0, 0, 0, 0, 0);
      check_eq("cont_w8", WriteReg, 8);
      idle();
      check_eq("cont_w3", WriteReg, 3);
      check_eq("cont_empty", fifo_count, 0);

      // Fill with the ALU busy, then drain in order; then wrap
      for (int i = 1; i <= 4; i++) step(0, 1, 10, i, 1, 5'(i), 64'h100 + i, 0, 0);
      check_eq("full_ready", lsu_ready, 0);
      check_eq("full_count", fifo_count, 4);
      for (int i = 1; i <= 4; i++) begin
         idle();
         check_eq("drain_reg", WriteReg, i);
      end
      for (int i = 5; i <= 6; i++) step(0, 1, 11, i, 1, 5'(i), 64'h200 + i, 0, 0);
      for (int i = 5; i <= 6; i++) begin
         idle();
         check_eq("wrap_reg", WriteReg, i);
      end

      // x0 load is consumed without a write
      step(0, 0, 0, 0, 1, 0, 64'hFF, 0, 0);
      check_eq("x0_cnt1", fifo_count, 1);
      idle();
      check_eq("x0_we", RegWrite, 0);
      check_eq("x0_cnt0", fifo_count, 0);

      // Set wins over same-cycle clear
      step(0, 0, 0, 0, 0, 0, 0, 1, 9);
      step(0, 1, 12, 64'hC, 1, 9, 64'h99, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 9);
      check_eq("setwins_we", WriteReg, 9);
      check_eq("setwins_busy9", busy[9], 1);

      // Reset mid-operation
      step(0, 0, 0, 0, 0, 0, 0, 1, 2);
      step(0, 0, 0, 0, 0, 0, 0, 1, 3);
      for (int i = 0; i < 3; i++) step(0, 1, 13, i, 1, 5'(20 + i), i, 0, 0);
      check_eq("pre_rst_cnt", fifo_count, 3);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("mid_rst_cnt", fifo_count, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_we", RegWrite, 0);
      check_eq("mid_rst_ready", lsu_ready, 1);
      idle(); idle();
      check_eq("no_stale_we", RegWrite, 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), {$urandom, $urandom},
              $urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)), {$urandom, $urandom},
              $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)));
      end
      for (int c = 0; c < 6; c++) idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
